// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, framed as start, 8 data
// bits LSB first, optional parity, then 1 or 2 stop bits at a fixed baud.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | line high, o_ready=1, waiting for i_tx_dv
// START  | driving the start bit (0) for one bit time
// DATA   | driving shift_reg[0]; bit_cnt holds the data index 0..7
// PARITY | driving the parity bit (only reachable when PARITY_EN=1)
// STOP   | driving 1; bit_cnt holds the stop index 0..STOP_BITS-1
module uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  output logic       o_ready,
  output logic       o_tx_serial,
  output logic       o_busy,
  output logic       o_done
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic            PAR_SEED  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic          bit_end;

  assign bit_end = (clk_cnt == CLK_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
      o_tx_serial <= 1'b1;
      o_ready     <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          o_tx_serial <= 1'b1;
          clk_cnt     <= '0;
          bit_cnt     <= '0;
          if (i_tx_dv) begin
            // Parity is computed from the byte as latched, so later shifting is harmless.
            shift_reg   <= i_tx_byte;
            parity_bit  <= (^i_tx_byte) ^ PAR_SEED;
            state       <= START;
            o_tx_serial <= 1'b0;
            o_busy      <= 1'b1;
            o_ready     <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            clk_cnt     <= '0;
            state       <= DATA;
            o_tx_serial <= shift_reg[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state       <= PARITY;
                o_tx_serial <= parity_bit;
              end else begin
                state       <= STOP;
                o_tx_serial <= 1'b1;
              end
            end else begin
              bit_cnt     <= bit_cnt + 1'b1;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              o_tx_serial <= shift_reg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (bit_end) begin
            clk_cnt     <= '0;
            state       <= STOP;
            o_tx_serial <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        STOP: begin
          o_tx_serial <= 1'b1;
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= IDLE;
              o_busy  <= 1'b0;
              o_ready <= 1'b1;
              o_done  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          clk_cnt     <= '0;
          bit_cnt     <= '0;
          o_tx_serial <= 1'b1;
          o_ready     <= 1'b1;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) at 4 clocks per bit,
// compared cycle by cycle against frames built from the byte and the framing rules.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int N   = 4;

  typedef bit         bitq_t[$];
  typedef logic [7:0] byteq_t[$];

  function automatic int cfg_pe(int g);
    return (g == 1 || g == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_po(int g);
    return (g == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_sb(int g);
    return (g == 3) ? 2 : 1;
  endfunction

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] dv;
  logic [7:0]   txb [N];
  logic [N-1:0] ready, serial, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (cfg_pe(g)),
      .PARITY_ODD  (cfg_po(g)),
      .STOP_BITS   (cfg_sb(g))
    ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_tx_dv    (dv[g]),
      .i_tx_byte  (txb[g]),
      .o_ready    (ready[g]),
      .o_tx_serial(serial[g]),
      .o_busy     (busy[g]),
      .o_done     (done[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line bits of one frame in transmit order, straight from the framing rules.
  function automatic bitq_t frame_bits(int k, logic [7:0] b);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
    if (cfg_pe(k) != 0) q.push_back((^b) ^ (cfg_po(k) != 0));
    for (int s = 0; s < cfg_sb(k); s++) q.push_back(1'b1);
    return q;
  endfunction

  task automatic check_idle(input int k, input string tag);
    check({tag, "_ser"},   serial[k], 1'b1);
    check({tag, "_rdy"},   ready[k],  1'b1);
    check({tag, "_busy"},  busy[k],   1'b0);
    check({tag, "_done"},  done[k],   1'b0);
  endtask

  // Sends bytes on instance k. hold keeps i_tx_dv high with the next byte for the
  // whole frame; junk_at pulses 0xFF at that cycle index of each frame.
  task automatic send_frames(input int k, input byteq_t bytes, input bit hold, input int junk_at);
    bitq_t      fb;
    logic [7:0] rx;
    int         n;
    n = bytes.size();
    @(negedge clk);
    check("ready_pre", ready[k], 1'b1);
    dv[k]  = 1'b1;
    txb[k] = bytes[0];
    for (int f = 0; f < n; f++) begin
      fb = frame_bits(k, bytes[f]);
      rx = '0;
      for (int i = 0; i < fb.size() * CPB; i++) begin
        @(negedge clk);
        check("line", serial[k], fb[i / CPB]);
        check("busy", busy[k],  1'b1);
        check("ready", ready[k], 1'b0);
        check("done_early", done[k], 1'b0);
        if (i % CPB == CPB / 2 && i / CPB >= 1 && i / CPB <= 8)
          rx[i / CPB - 1] = serial[k];
        if (hold && f + 1 < n) begin
          dv[k]  = 1'b1;
          txb[k] = bytes[f + 1];
        end else if (i == junk_at) begin
          dv[k]  = 1'b1;
          txb[k] = 8'hFF;
        end else begin
          dv[k] = 1'b0;
        end
      end
      @(negedge clk);
      check("done", done[k], 1'b1);
      check("busy_end", busy[k], 1'b0);
      check("ready_end", ready[k], 1'b1);
      check("idle_gap", serial[k], 1'b1);
      check("rx_byte", rx, bytes[f]);
      if (f + 1 < n) begin
        dv[k]  = 1'b1;
        txb[k] = bytes[f + 1];
      end else begin
        dv[k] = 1'b0;
      end
    end
    @(negedge clk);
    check("done_once", done[k], 1'b0);
    check("idle_after", serial[k], 1'b1);
  endtask

  task automatic mid_reset(input int k, input logic [7:0] b);
    byteq_t q;
    @(negedge clk);
    dv[k]  = 1'b1;
    txb[k] = b;
    @(negedge clk);
    dv[k] = 1'b0;
    repeat (4 * CPB + 1) @(negedge clk);
    check("mid_bit3", serial[k], b[3]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle(k, "mid_rst");
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      check("mid_nodone", done[k], 1'b0);
      check("mid_line", serial[k], 1'b1);
    end
    q.push_back(8'h61);
    send_frames(k, q, 1'b0, -1);
  endtask

  initial begin
    byteq_t q;
    int     k, n, junk;
    bit     hold;

    rst = 1'b1;
    dv  = '0;
    for (int i = 0; i < N; i++) txb[i] = 8'h00;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) check_idle(i, "reset");
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) check_idle(i, "post_reset");

    q.delete(); q.push_back(8'h61); send_frames(0, q, 1'b0, -1);
    q.delete(); q.push_back(8'h61); send_frames(1, q, 1'b0, -1);
    q.delete(); q.push_back(8'h00); send_frames(2, q, 1'b0, -1);
    q.delete(); q.push_back(8'hA5); q.push_back(8'h3C); send_frames(3, q, 1'b1, -1);
    q.delete(); q.push_back(8'h55); send_frames(0, q, 1'b0, 2 * CPB + 1);
    q.delete(); q.push_back(8'h55); send_frames(3, q, 1'b0, 6 * CPB);

    // Reset and valid on the same edge: the byte must not be taken.
    @(negedge clk);
    rst    = 1'b1;
    dv[0]  = 1'b1;
    txb[0] = 8'h77;
    @(negedge clk);
    rst   = 1'b0;
    dv[0] = 1'b0;
    check_idle(0, "rst_wins");
    @(negedge clk);
    check("rst_wins_line", serial[0], 1'b1);
    check("rst_wins_busy", busy[0], 1'b0);

    mid_reset(0, 8'h5A);
    mid_reset(3, 8'hC3);

    for (int r = 0; r < 16; r++) begin
      k    = $urandom_range(0, N - 1);
      n    = $urandom_range(1, 3);
      hold = 1'($urandom_range(0, 1));
      junk = ($urandom_range(0, 1) != 0) ? $urandom_range(CPB, 8 * CPB) : -1;
      q.delete();
      for (int j = 0; j < n; j++) q.push_back(8'($urandom));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send_frames(k, q, hold, junk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
